uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter for the CPU's I/O space. It is the outbound counterpart of the UART programmer receiver. The CPU writes bytes through the I/O decode, and the block queues them in a small FIFO. Each byte is serialised as 8N1 (optionally 8E1) on the `uart_tx` pin. A status word lets software poll for space and completion.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 23_000_000: frequency of `clk`.
- `BAUD`, default 115_200: line rate. The bit period is `DIV = CLK_FREQ_HZ / BAUD`, truncated, and must be ≥ 2.
- `FIFO_DEPTH`, default 8: number of queued bytes. Must be a power of two, from 2 to 128.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `tx_cs` in 1: chip select from the I/O address decode.
- `tx_wen` in 1: write strobe. Qualified by `tx_cs`.
- `tx_ren` in 1: read strobe. Qualified by `tx_cs`.
- `tx_addr` in 2: register select. 0 = DATA (write), 1 = STATUS (read). Other values are ignored.
- `tx_wdata` in 8: byte to transmit.
- `tx_rdata` out 32: registered read data.
- `tx_full` out 1: the FIFO is full.
- `tx_busy` out 1: the FIFO is non-empty or a frame is in flight.
- `uart_tx` out 1: serial line. Idles high.

## Operation
- **Push:** `tx_cs & tx_wen & tx_addr==0` pushes `tx_wdata` when the FIFO is not full.
  - Fullness is evaluated before any same-cycle pop.
  - A write while full is dropped and sets the sticky `overflow` bit.
- **Status read:** `tx_cs & tx_ren & tx_addr==1` loads STATUS into `tx_rdata` and clears `overflow`.
  - If an overflow happens in the same cycle, `overflow` stays set.
  - A read at any other address loads 0.
- **STATUS layout:**
  - bit0 `busy`
  - bit1 `full`
  - bit2 `empty`
  - bit3 `overflow`
  - bits[15:8] `count`
  - all other bits 0
- **States:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE & count>0 → pop the head into the shift register, go to START, clear the baud counter.
  - START → DATA after DIV cycles. `uart_tx`=0 during START.
  - DATA: shift out LSB first, DIV cycles per bit. After bit 7, go to PARITY or STOP.
  - PARITY → STOP after DIV cycles.
  - STOP: `uart_tx`=1 for DIV cycles. At the end, if count>0, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- **Counters:**
  - The baud counter runs 0..DIV-1 and wraps. It runs only outside IDLE.
  - The bit index is 3 bits and wraps 7→0.
- **FIFO:** circular buffer with `log2(FIFO_DEPTH)`-bit pointers that wrap naturally. `count` has `log2(FIFO_DEPTH)+1` bits.
  - A simultaneous push and pop (not full) leaves `count` unchanged.
  - A push and pop on an empty FIFO cannot coincide: a pop requires count>0 at the edge.
- **Reset mid-frame:** the frame is aborted. `uart_tx` returns high the cycle after the `rst` edge, and the FIFO is flushed.

## Timing
- **Reset values:**
  - `uart_tx`=1
  - `tx_rdata`=0
  - `tx_full`=0
  - `tx_busy`=0
  - `overflow`=0
  - FIFO empty, state IDLE
- `uart_tx` is driven from a register, so it is glitch-free.
- **Latency:** a write accepted at edge N into an empty FIFO while IDLE gives `uart_tx`=0 from edge N+1.
- **Frame length:** 10·DIV cycles, or 11·DIV with parity.
- **Back-to-back frames** are contiguous: the next start bit begins exactly after the stop bit's DIV cycles.
- `tx_rdata` is valid the cycle after the read strobe and holds until the next read.
- `tx_full` and `tx_busy` are registered and reflect the state after each edge.

## Configuration
- **`UART_TX_PARITY_EN` defined:** an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and stop. The frame is 11 bit periods.
- **Undefined:** the PARITY state and its logic are absent. The frame is 8N1.

## Structure
- **Package `uart_tx_pkg`:** state encoding, register address constants (`ADDR_DATA`=0, `ADDR_STATUS`=1), STATUS bit positions.
- **Sub-module `tx_fifo`:** synchronous FIFO with parameter `DEPTH`. Ports: push, pop, din, dout, full, empty, count. The top instantiates one.

## Test plan
Use `CLK_FREQ_HZ`=4, `BAUD`=1 (DIV=4) and `FIFO_DEPTH`=4.
- **Single byte:** write 0x55 when idle.
  - Line: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - `tx_busy` falls 40 cycles after the start edge.
- **Back-to-back:** write 0x00 and then 0xFF on consecutive cycles.
  - Two contiguous frames, 80 cycles total, with no idle gap between the stop bit and the second start bit.
- **Overflow:** write 6 bytes in consecutive cycles while idle.
  - The first is popped immediately, so bytes 1–5 fill the FIFO, and 4 queued plus 1 in flight means byte 6 is dropped.
  - STATUS reads `full`=1, `overflow`=1, `count`=4.
  - A second STATUS read shows `overflow`=0.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 3 of 0xA5.
  - `uart_tx`=1 and `tx_busy`=0 the next cycle.
  - STATUS = 0x0000_0004.
- **Parity (macro on):** write 0x07.
  - The bit after data is 1 (three ones), followed by the stop bit. Frame length 44 cycles.
- **Simultaneous write and pop when full:** FIFO full, with STOP ending in the same cycle as a write.
  - The write is dropped and `overflow`=1.
  - `count` drops to 3.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared types and constants for the uart_tx_port transmitter.
//               The PARITY state exists only when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;

   localparam int c_stat_busy    = 0;
   localparam int c_stat_full    = 1;
   localparam int c_stat_empty   = 2;
   localparam int c_stat_ovf     = 3;
   localparam int c_stat_cnt_lsb = 8;

   function automatic logic [31:0] build_status(input logic       busy,
                                                input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [7:0] count);
      logic [31:0] s;
      s                               = '0;
      s[c_stat_busy]                  = busy;
      s[c_stat_full]                  = full;
      s[c_stat_empty]                 = empty;
      s[c_stat_ovf]                   = ovf;
      s[c_stat_cnt_lsb +: 8]          = count;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_port_if.sv
// ============================================================================
// Module      : uart_tx_port_if
// Description : CPU I/O-space bus between the address decode and the UART
//               transmitter (macro UART_TX_PARITY_EN has no effect here).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_port_if;
   logic        tx_cs;
   logic        tx_wen;
   logic        tx_ren;
   logic [1:0]  tx_addr;
   logic [7:0]  tx_wdata;
   logic [31:0] tx_rdata;
   logic        tx_full;
   logic        tx_busy;

   modport master (
      output tx_cs, tx_wen, tx_ren, tx_addr, tx_wdata,
      input  tx_rdata, tx_full, tx_busy
   );

   modport slave (
      input  tx_cs, tx_wen, tx_ren, tx_addr, tx_wdata,
      output tx_rdata, tx_full, tx_busy
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_port_fifo.sv
// ============================================================================
// Module      : tx_fifo
// Description : Byte-wide synchronous circular FIFO with registered full/empty
//               flags (independent of UART_TX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
   parameter int DEPTH = 8
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire logic [7:0]                 din,
   output logic      [7:0]                 dout,
   output logic                            full,
   output logic                            empty,
   output logic      [$clog2(DEPTH):0]     count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [7:0]      r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            r_full;
   logic            r_empty;

   logic            w_push_ok;
   logic            w_pop_ok;
   logic [c_aw:0]   w_count_nxt;

   assign w_push_ok   = push & ~r_full;
   assign w_pop_ok    = pop & ~r_empty;
   assign w_count_nxt = r_count + (c_aw+1)'(w_push_ok) - (c_aw+1)'(w_pop_ok);

   // Storage is not reset; flushing is done by clearing the pointers.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (c_aw+1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_port.sv
// ============================================================================
// Module      : uart_tx_port
// Description : Memory-mapped 8N1 UART transmitter with byte FIFO and STATUS
//               register. Define UART_TX_PARITY_EN for 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_port
   import uart_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 23_000_000,
   parameter int BAUD        = 115_200,
   parameter int FIFO_DEPTH  = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   uart_tx_port_if.slave bus,
   output logic          uart_tx
);

   localparam int              c_div       = CLK_FREQ_HZ / BAUD;
   localparam int              c_bw        = (c_div > 1) ? $clog2(c_div) : 1;
   localparam int              c_aw        = $clog2(FIFO_DEPTH);
   localparam logic [c_bw-1:0] c_baud_last = c_bw'(c_div - 1);

   tx_state_t       r_state;
   logic [c_bw-1:0] r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_tx;
   logic            r_busy;
   logic            r_ovf;
   logic [31:0]     r_rdata;
`ifdef UART_TX_PARITY_EN
   logic            r_par;
`endif

   logic            w_wr;
   logic            w_rd;
   logic            w_stat_rd;
   logic            w_push;
   logic            w_pop;
   logic            w_ovf_set;
   logic            w_bit_end;
   logic            w_frame_nxt;
   logic [7:0]      w_dout;
   logic            w_full;
   logic            w_empty;
   logic [c_aw:0]   w_count;
   logic [c_aw:0]   w_count_nxt;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (bus.tx_wdata),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   assign w_wr      = bus.tx_cs & bus.tx_wen & (bus.tx_addr == ADDR_DATA);
   assign w_rd      = bus.tx_cs & bus.tx_ren;
   assign w_stat_rd = w_rd & (bus.tx_addr == ADDR_STATUS);
   // Fullness is the pre-edge flag, so a write racing a pop is still dropped.
   assign w_push    = w_wr & ~w_full;
   assign w_ovf_set = w_wr & w_full;
   assign w_bit_end = (r_baud == c_baud_last);
   assign w_pop     = ~w_empty & ((r_state == ST_IDLE) |
                                  ((r_state == ST_STOP) & w_bit_end));
   assign w_count_nxt = w_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);

   always_comb begin
      w_frame_nxt = 1'b1;
      if (r_state == ST_IDLE) begin
         w_frame_nxt = ~w_empty;
      end else if ((r_state == ST_STOP) && w_bit_end && w_empty) begin
         w_frame_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         if (r_state == ST_IDLE || w_bit_end) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + c_bw'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_shift <= w_dout;
                  r_state <= ST_START;
                  r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  r_par   <= ^w_dout;
`endif
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_bit <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (w_bit_end) begin
                  // Chain straight into the next start bit when data is queued.
                  if (!w_empty) begin
                     r_shift <= w_dout;
                     r_state <= ST_START;
                     r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     r_par   <= ^w_dout;
`endif
                  end else begin
                     r_state <= ST_IDLE;
                     r_tx    <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_busy <= w_frame_nxt | (w_count_nxt != '0);
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
         end
         if (w_rd) begin
            r_rdata <= w_stat_rd ? build_status(r_busy, w_full, w_empty, r_ovf, 8'(w_count))
                                 : 32'd0;
         end
      end
   end

   assign uart_tx      = r_tx;
   assign bus.tx_rdata = r_rdata;
   assign bus.tx_full  = w_full;
   assign bus.tx_busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_port.sv
// ============================================================================
// Module      : tb_uart_tx_port
// Description : Directed self-checking bench for uart_tx_port (DIV=4, depth 4);
//               adds a parity scenario when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_port;

`ifdef UART_TX_PARITY_EN
   localparam int c_nper = 11;
`else
   localparam int c_nper = 10;
`endif

   logic clk;
   logic rst;
   logic uart_tx;
   int   errors;
   int   checks;

   uart_tx_port_if bus_if ();

   uart_tx_port #(
      .CLK_FREQ_HZ (4),
      .BAUD        (1),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .uart_tx (uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      bus_if.tx_cs    = 1'b1;
      bus_if.tx_wen   = 1'b1;
      bus_if.tx_addr  = 2'd0;
      bus_if.tx_wdata = b;
      @(posedge clk);
      #1;
      bus_if.tx_cs    = 1'b0;
      bus_if.tx_wen   = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      bus_if.tx_cs   = 1'b1;
      bus_if.tx_ren  = 1'b1;
      bus_if.tx_addr = a;
      @(posedge clk);
      #1;
      bus_if.tx_cs   = 1'b0;
      bus_if.tx_ren  = 1'b0;
      v = bus_if.tx_rdata;
   endtask

   // Call right after the start edge; samples every cycle of the frame.
   task automatic check_frame(input logic [7:0] b);
      logic exp;
      int   p;
      for (int j = 0; j < c_nper * 4; j++) begin
         @(negedge clk);
         p = j / 4;
         if (p == 0)                        exp = 1'b0;
         else if (p <= 8)                   exp = b[p-1];
         else if (p == 9 && c_nper == 11)   exp = ^b;
         else                               exp = 1'b1;
         checks++;
         if (uart_tx !== exp) begin
            errors++;
            $display("FAIL frame_%02h cycle %0d: uart_tx=%b expected %b", b, j, uart_tx, exp);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({uart_tx, bus_if.tx_full, bus_if.tx_busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_outputs: tx/full/busy=%b expected 100",
                  {uart_tx, bus_if.tx_full, bus_if.tx_busy});
      end
      checks++;
      if (bus_if.tx_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %08h expected 00000000", bus_if.tx_rdata);
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("FAIL reset_status: got %08h expected 00000004", v);
      end
   endtask

   task automatic test_single_byte();
      do_reset();
      write_byte(8'h55);
      @(posedge clk);
      check_frame(8'h55);
      checks++;
      if (bus_if.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_last: got %b expected 1", bus_if.tx_busy);
      end
      @(negedge clk);
      checks++;
      if ({bus_if.tx_busy, uart_tx} !== 2'b01) begin
         errors++;
         $display("FAIL single_busy_fall: busy/tx=%b expected 01", {bus_if.tx_busy, uart_tx});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      write_byte(8'h00);
      write_byte(8'hFF);
      check_frame(8'h00);
      check_frame(8'hFF);
      @(negedge clk);
      checks++;
      if ({bus_if.tx_busy, uart_tx} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_idle: busy/tx=%b expected 01", {bus_if.tx_busy, uart_tx});
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i));
      checks++;
      if (bus_if.tx_full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_full_pin: got %b expected 1", bus_if.tx_full);
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'h0000_040B) begin
         errors++;
         $display("FAIL ovf_status1: got %08h expected 0000040b", v);
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'h0000_0403) begin
         errors++;
         $display("FAIL ovf_status2: got %08h expected 00000403", v);
      end
      read_reg(2'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL other_addr_read: got %08h expected 00000000", v);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] v;
      do_reset();
      write_byte(8'hA5);
      repeat (19) @(posedge clk);
      #1;
      checks++;
      if (uart_tx !== 1'b0) begin
         errors++;
         $display("FAIL midframe_bit3: uart_tx=%b expected 0", uart_tx);
      end
      do_reset();
      checks++;
      if ({uart_tx, bus_if.tx_busy, bus_if.tx_full} !== 3'b100) begin
         errors++;
         $display("FAIL midframe_abort: tx/busy/full=%b expected 100",
                  {uart_tx, bus_if.tx_busy, bus_if.tx_full});
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("FAIL midframe_status: got %08h expected 00000004", v);
      end
   endtask

   task automatic test_full_write_pop();
      logic [31:0] v;
      do_reset();
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      write_byte(8'h55);
      repeat (36) @(posedge clk);
      #1;
      checks++;
      if ({bus_if.tx_full, uart_tx} !== 2'b11) begin
         errors++;
         $display("FAIL fullpop_pre: full/tx=%b expected 11", {bus_if.tx_full, uart_tx});
      end
      write_byte(8'h66);
      checks++;
      if ({bus_if.tx_full, uart_tx} !== 2'b00) begin
         errors++;
         $display("FAIL fullpop_post: full/tx=%b expected 00", {bus_if.tx_full, uart_tx});
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== 32'h0000_0309) begin
         errors++;
         $display("FAIL fullpop_status: got %08h expected 00000309", v);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      do_reset();
      write_byte(8'h07);
      @(posedge clk);
      check_frame(8'h07);
      @(negedge clk);
      checks++;
      if (bus_if.tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL parity_len: busy=%b expected 0 after 44 cycles", bus_if.tx_busy);
      end
   endtask
`endif

   initial begin
      errors          = 0;
      checks          = 0;
      rst             = 1'b1;
      bus_if.tx_cs    = 1'b0;
      bus_if.tx_wen   = 1'b0;
      bus_if.tx_ren   = 1'b0;
      bus_if.tx_addr  = 2'd0;
      bus_if.tx_wdata = 8'd0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_full_write_pop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
